// File: rtl/fma_align_sum_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fma_align_sum_pipe
//  Description : Two-stage align-and-add stage of a generic-width FMA.
//                Stage 1 aligns the addend against the product with a
//                right-only shift and collects the alignment sticky bit.
//                Stage 2 adds or subtracts, takes the magnitude, resolves
//                the result sign and counts leading zeros.
//                Valid/ready handshake, 1 op/cycle, 2-cycle latency.
//  Ports       : clk, reset (sync, active-high)
//                in_valid/in_ready, ps, zs, pe, ze, pm, zm, prod_zero,
//                z_zero, rm_down, tag_in                       -> operation
//                out_valid/out_ready, sum, sign, se, lzc, sticky,
//                kill_prod, kill_z, tag_out                    -> result
//  Revision    : 1.0  initial release
// ============================================================================
module fma_align_sum_pipe #(
    parameter int NF   = 10,
    parameter int NE   = 5,
    parameter int TAGW = 4,
    parameter int W    = 3*NF+6,
    parameter int LZW  = $clog2(W+1),
    parameter int AW   = NE+3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            ps,
    input  logic            zs,
    input  logic [NE+1:0]   pe,
    input  logic [NE-1:0]   ze,
    input  logic [2*NF+1:0] pm,
    input  logic [NF:0]     zm,
    input  logic            prod_zero,
    input  logic            z_zero,
    input  logic            rm_down,
    input  logic [TAGW-1:0] tag_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    sum,
    output logic            sign,
    output logic [NE+1:0]   se,
    output logic [LZW-1:0]  lzc,
    output logic            sticky,
    output logic            kill_prod,
    output logic            kill_z,
    output logic [TAGW-1:0] tag_out
);

    // Alignment offset: addend MSB sits NF+3 bits above the product MSB
    // when exponents are equal.
    localparam logic [AW-1:0]        C_ALIGN_OFF = AW'(NF+3);
    localparam logic [NE+1:0]        C_SE_OFF    = (NE+2)'(NF+3);
    localparam logic signed [AW-1:0] C_WMAX      = AW'(W-1);

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic r_s1_valid_q, w_s1_valid_d;
    logic r_out_valid_q, w_out_valid_d;
    logic w_s2_adv, w_s1_adv;

    assign w_s2_adv = ~r_out_valid_q | out_ready;
    assign w_s1_adv = ~r_s1_valid_q | w_s2_adv;
    assign in_ready = w_s1_adv;

    // ------------------------------------------------------------------
    // Stage 1: alignment
    // ------------------------------------------------------------------
    logic signed [AW-1:0] w_acnt;
    logic [AW-1:0]        w_sh;
    logic [W-1:0]         w_zbase, w_pvec_raw, w_zshift;
    logic                 w_zlost;
    logic [NE+1:0]        w_se_p;

    logic [W-1:0]    r_s1_am_q, w_s1_am_d;
    logic [W-1:0]    r_s1_pvec_q, w_s1_pvec_d;
    logic            r_s1_sticky_q, w_s1_sticky_d;
    logic [NE+1:0]   r_s1_se_q, w_s1_se_d;
    logic            r_s1_kp_q, w_s1_kp_d;
    logic            r_s1_kz_q, w_s1_kz_d;
    logic            r_s1_ps_q, w_s1_ps_d;
    logic            r_s1_zs_q, w_s1_zs_d;
    logic            r_s1_pz_q, w_s1_pz_d;
    logic            r_s1_zz_q, w_s1_zz_d;
    logic            r_s1_rmd_q, w_s1_rmd_d;
    logic [TAGW-1:0] r_s1_tag_q, w_s1_tag_d;

    assign w_acnt     = $signed({pe[NE+1], pe} - {3'b000, ze} + C_ALIGN_OFF);
    assign w_sh       = w_acnt;
    assign w_zbase    = {zm, {(2*NF+5){1'b0}}};
    assign w_pvec_raw = prod_zero ? '0 : {{(NF+2){1'b0}}, pm, 2'b00};
    assign w_zshift   = w_zbase >> w_sh;
    // Bits of the addend that fall below the window after the shift.
    assign w_zlost    = |(w_zbase & ~({W{1'b1}} << w_sh));
    assign w_se_p     = pe + C_SE_OFF;

    always_comb begin
        w_s1_valid_d  = r_s1_valid_q;
        w_s1_am_d     = r_s1_am_q;
        w_s1_pvec_d   = r_s1_pvec_q;
        w_s1_sticky_d = r_s1_sticky_q;
        w_s1_se_d     = r_s1_se_q;
        w_s1_kp_d     = r_s1_kp_q;
        w_s1_kz_d     = r_s1_kz_q;
        w_s1_ps_d     = r_s1_ps_q;
        w_s1_zs_d     = r_s1_zs_q;
        w_s1_pz_d     = r_s1_pz_q;
        w_s1_zz_d     = r_s1_zz_q;
        w_s1_rmd_d    = r_s1_rmd_q;
        w_s1_tag_d    = r_s1_tag_q;
        if (w_s1_adv) begin
            w_s1_valid_d = in_valid;
            if (in_valid) begin
                w_s1_ps_d   = ps;
                w_s1_zs_d   = zs;
                w_s1_pz_d   = prod_zero;
                w_s1_zz_d   = z_zero;
                w_s1_rmd_d  = rm_down;
                w_s1_tag_d  = tag_in;
                w_s1_pvec_d = w_pvec_raw;
                w_s1_kp_d   = 1'b0;
                w_s1_kz_d   = 1'b0;
                if (prod_zero) begin
                    w_s1_am_d     = w_zbase;
                    w_s1_sticky_d = 1'b0;
                    w_s1_se_d     = {2'b00, ze};
                end else if (w_acnt[AW-1]) begin
                    // Product lies wholly below the addend LSB.
                    w_s1_kp_d     = 1'b1;
                    w_s1_am_d     = w_zbase;
                    w_s1_pvec_d   = '0;
                    w_s1_sticky_d = |pm;
                    w_s1_se_d     = {2'b00, ze};
                end else if (w_acnt > C_WMAX) begin
                    w_s1_kz_d     = 1'b1;
                    w_s1_am_d     = '0;
                    w_s1_sticky_d = (|zm) & ~z_zero;
                    w_s1_se_d     = w_se_p;
                end else begin
                    w_s1_am_d     = w_zshift;
                    w_s1_sticky_d = w_zlost;
                    w_s1_se_d     = w_se_p;
                end
                if (z_zero) begin
                    w_s1_am_d     = '0;
                    w_s1_sticky_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid_q  <= 1'b0;
            r_s1_am_q     <= '0;
            r_s1_pvec_q   <= '0;
            r_s1_sticky_q <= 1'b0;
            r_s1_se_q     <= '0;
            r_s1_kp_q     <= 1'b0;
            r_s1_kz_q     <= 1'b0;
            r_s1_ps_q     <= 1'b0;
            r_s1_zs_q     <= 1'b0;
            r_s1_pz_q     <= 1'b0;
            r_s1_zz_q     <= 1'b0;
            r_s1_rmd_q    <= 1'b0;
            r_s1_tag_q    <= '0;
        end else begin
            r_s1_valid_q  <= w_s1_valid_d;
            r_s1_am_q     <= w_s1_am_d;
            r_s1_pvec_q   <= w_s1_pvec_d;
            r_s1_sticky_q <= w_s1_sticky_d;
            r_s1_se_q     <= w_s1_se_d;
            r_s1_kp_q     <= w_s1_kp_d;
            r_s1_kz_q     <= w_s1_kz_d;
            r_s1_ps_q     <= w_s1_ps_d;
            r_s1_zs_q     <= w_s1_zs_d;
            r_s1_pz_q     <= w_s1_pz_d;
            r_s1_zz_q     <= w_s1_zz_d;
            r_s1_rmd_q    <= w_s1_rmd_d;
            r_s1_tag_q    <= w_s1_tag_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: add / subtract, magnitude, sign, leading-zero count
    // ------------------------------------------------------------------
    logic           w_eff_sub;
    logic [W:0]     w_diff;
    logic [W-1:0]   w_mag;
    logic           w_sign;
    logic [LZW-1:0] w_lzc;

    assign w_eff_sub = (r_s1_ps_q ^ r_s1_zs_q) & ~r_s1_zz_q & ~r_s1_pz_q;
    assign w_diff    = {1'b0, r_s1_pvec_q} - {1'b0, r_s1_am_q};

    always_comb begin
        if (w_eff_sub) begin
            // Borrow out of the extended subtraction marks a negative result.
            w_mag  = w_diff[W] ? (~w_diff[W-1:0] + 1'b1) : w_diff[W-1:0];
            w_sign = w_diff[W] ? r_s1_zs_q : r_s1_ps_q;
        end else begin
            w_mag  = r_s1_pvec_q + r_s1_am_q;
            w_sign = r_s1_pz_q ? r_s1_zs_q : r_s1_ps_q;
        end
        if ((w_mag == '0) && !r_s1_sticky_q) begin
            if (w_eff_sub)
                w_sign = r_s1_rmd_q;
            else
                w_sign = r_s1_pz_q ? r_s1_zs_q : (r_s1_ps_q & r_s1_zs_q);
        end
    end

    // Priority count from the MSB: the highest set bit wins.
    always_comb begin
        w_lzc = LZW'(W);
        for (int i = 0; i < W; i++) begin
            if (w_mag[i]) w_lzc = LZW'(W - 1 - i);
        end
    end

    logic [W-1:0]    r_sum_q, w_sum_d;
    logic            r_sign_q, w_sign_d;
    logic [NE+1:0]   r_se_q, w_se_d;
    logic [LZW-1:0]  r_lzc_q, w_lzc_d;
    logic            r_sticky_q, w_sticky_d;
    logic            r_kp_q, w_kp_d;
    logic            r_kz_q, w_kz_d;
    logic [TAGW-1:0] r_tag_q, w_tag_d;

    always_comb begin
        w_out_valid_d = r_out_valid_q;
        w_sum_d       = r_sum_q;
        w_sign_d      = r_sign_q;
        w_se_d        = r_se_q;
        w_lzc_d       = r_lzc_q;
        w_sticky_d    = r_sticky_q;
        w_kp_d        = r_kp_q;
        w_kz_d        = r_kz_q;
        w_tag_d       = r_tag_q;
        if (w_s2_adv) begin
            w_out_valid_d = r_s1_valid_q;
            if (r_s1_valid_q) begin
                w_sum_d    = w_mag;
                w_sign_d   = w_sign;
                w_se_d     = r_s1_se_q;
                w_lzc_d    = w_lzc;
                w_sticky_d = r_s1_sticky_q;
                w_kp_d     = r_s1_kp_q;
                w_kz_d     = r_s1_kz_q;
                w_tag_d    = r_s1_tag_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid_q <= 1'b0;
            r_sum_q       <= '0;
            r_sign_q      <= 1'b0;
            r_se_q        <= '0;
            r_lzc_q       <= '0;
            r_sticky_q    <= 1'b0;
            r_kp_q        <= 1'b0;
            r_kz_q        <= 1'b0;
            r_tag_q       <= '0;
        end else begin
            r_out_valid_q <= w_out_valid_d;
            r_sum_q       <= w_sum_d;
            r_sign_q      <= w_sign_d;
            r_se_q        <= w_se_d;
            r_lzc_q       <= w_lzc_d;
            r_sticky_q    <= w_sticky_d;
            r_kp_q        <= w_kp_d;
            r_kz_q        <= w_kz_d;
            r_tag_q       <= w_tag_d;
        end
    end

    assign out_valid = r_out_valid_q;
    assign sum       = r_sum_q;
    assign sign      = r_sign_q;
    assign se        = r_se_q;
    assign lzc       = r_lzc_q;
    assign sticky    = r_sticky_q;
    assign kill_prod = r_kp_q;
    assign kill_z    = r_kz_q;
    assign tag_out   = r_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_fma_align_sum_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fma_align_sum_pipe
//  Description : Self-checking bench for fma_align_sum_pipe (NF=10, NE=5).
//                Directed cases with fixed expected results, backpressure
//                and mid-flight reset, then randomized traffic against an
//                arithmetic reference model and an in-order scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fma_align_sum_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        ps = 1'b0, zs = 1'b0;
    logic [6:0]  pe = '0;
    logic [4:0]  ze = '0;
    logic [21:0] pm = '0;
    logic [10:0] zm = '0;
    logic        prod_zero = 1'b0, z_zero = 1'b0, rm_down = 1'b0;
    logic [3:0]  tag_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [35:0] sum;
    logic        sign;
    logic [6:0]  se;
    logic [5:0]  lzc;
    logic        sticky, kill_prod, kill_z;
    logic [3:0]  tag_out;

    fma_align_sum_pipe #(.NF(10), .NE(5), .TAGW(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .ps(ps), .zs(zs), .pe(pe), .ze(ze), .pm(pm), .zm(zm),
        .prod_zero(prod_zero), .z_zero(z_zero), .rm_down(rm_down),
        .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .sign(sign), .se(se), .lzc(lzc), .sticky(sticky),
        .kill_prod(kill_prod), .kill_z(kill_z), .tag_out(tag_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic ps, zs;
        logic [6:0] pe;
        logic [4:0] ze;
        logic [21:0] pm;
        logic [10:0] zm;
        logic pz, zz, rmd;
        logic [3:0] tag;
        bit has_gold;
        logic [56:0] gold;
    } stim_t;

    typedef struct {
        logic [56:0] exp;
        bit has_gold;
        logic [56:0] gold;
        int acc_cyc;
    } sb_t;

    stim_t stim_q[$];
    sb_t   sb_q[$];
    int n_checks = 0, n_errors = 0;
    int cyc = 0, n_acc = 0, n_outv = 0;
    bit front_seen = 0;
    logic last_in_ready;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [56:0] pk(logic [35:0] s, logic sg, logic [6:0] e,
                                       logic [5:0] lz, logic st, logic kp, logic kz,
                                       logic [3:0] t);
        return {s, sg, e, lz, st, kp, kz, t};
    endfunction

    // Reference: exact integer arithmetic on the aligned operands.
    function automatic logic [56:0] model(input stim_t s);
        int     acnt, se_i, lz;
        longint zv, pv, av, r, mag, one;
        bit     st, kp, kz, sub, sg;
        logic [63:0] mv;
        one  = 1;
        acnt = int'($signed(s.pe)) - int'(s.ze) + 13;
        zv   = longint'(s.zm) << 25;
        pv   = s.pz ? 64'sd0 : (longint'(s.pm) << 2);
        st = 0; kp = 0; kz = 0;
        if (s.pz) begin
            av = zv; se_i = int'(s.ze);
        end else if (acnt < 0) begin
            kp = 1; av = zv; pv = 0; st = (s.pm != 0); se_i = int'(s.ze);
        end else if (acnt > 35) begin
            kz = 1; av = 0; st = (s.zm != 0) && !s.zz; se_i = int'($signed(s.pe)) + 13;
        end else begin
            av = zv >> acnt;
            st = (zv & ((one << acnt) - 1)) != 0;
            se_i = int'($signed(s.pe)) + 13;
        end
        if (s.zz) begin av = 0; st = 0; end
        sub = (s.ps ^ s.zs) && !s.zz && !s.pz;
        if (sub) begin
            r = pv - av;
            sg = (r < 0) ? s.zs : s.ps;
            mag = (r < 0) ? -r : r;
        end else begin
            mag = pv + av;
            sg = s.pz ? s.zs : s.ps;
        end
        if (mag == 0 && !st)
            sg = sub ? s.rmd : (s.pz ? s.zs : (s.ps & s.zs));
        mv = mag;
        lz = 0;
        while (lz < 36 && !mv[35-lz]) lz++;
        return pk(mv[35:0], sg, 7'(se_i), 6'(lz), st, kp, kz, s.tag);
    endfunction

    function automatic stim_t mk(logic a_ps, logic a_zs, int a_pe, int a_ze,
                                 logic [21:0] a_pm, logic [10:0] a_zm, logic a_rmd,
                                 logic [3:0] a_tag);
        stim_t s;
        s.ps = a_ps; s.zs = a_zs; s.pe = 7'(a_pe); s.ze = 5'(a_ze);
        s.pm = a_pm; s.zm = a_zm; s.pz = 0; s.zz = 0; s.rmd = a_rmd;
        s.tag = a_tag; s.has_gold = 0; s.gold = '0;
        return s;
    endfunction

    function automatic stim_t rnd_stim();
        stim_t s;
        int mx, my;
        mx = $urandom_range(1024, 2047);
        my = $urandom_range(1024, 2047);
        s = mk($urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,70) - 20,
               $urandom_range(0,31), 22'(mx * my), 11'($urandom_range(1024, 2047)),
               $urandom_range(0,1), 4'($urandom_range(0,15)));
        if ($urandom_range(0,3) == 0) s.ze = 5'(($signed(s.pe) < 0) ? 0 :
                                               ($signed(s.pe) > 31 ? 31 : int'(s.pe)));
        if ($urandom_range(0,9) == 0) begin s.ze = 0; s.zm = 11'($urandom_range(0,1023)); end
        if ($urandom_range(0,9) == 0) begin s.pz = 1; s.pm = 0; end
        if ($urandom_range(0,9) == 0) begin s.zz = 1; s.zm = 0; s.ze = 0; end
        return s;
    endfunction

    function automatic logic [56:0] dut_pk();
        return pk(sum, sign, se, lzc, sticky, kill_prod, kill_z, tag_out);
    endfunction

    // One clock cycle: drive at the falling edge, sample 1 time unit later,
    // the transfers then happen on the following rising edge.
    task automatic step(input bit oready, input bit gaps);
        sb_t e;
        @(negedge clk);
        out_ready = oready;
        if (stim_q.size() > 0 && !(gaps && $urandom_range(0,3) == 0)) begin
            in_valid = 1; ps = stim_q[0].ps; zs = stim_q[0].zs; pe = stim_q[0].pe;
            ze = stim_q[0].ze; pm = stim_q[0].pm; zm = stim_q[0].zm;
            prod_zero = stim_q[0].pz; z_zero = stim_q[0].zz; rm_down = stim_q[0].rmd;
            tag_in = stim_q[0].tag;
        end else begin
            in_valid = 0;
        end
        #1;
        if (out_valid) begin
            n_outv++;
            if (sb_q.size() == 0) begin
                chk("spurious_out", 64'(out_valid), 64'd0);
            end else begin
                chk("result", 64'(dut_pk()), 64'(sb_q[0].exp));
                if (sb_q[0].has_gold) begin
                    chk("golden", 64'(dut_pk()), 64'(sb_q[0].gold));
                    if (!front_seen) chk("latency", 64'(cyc - sb_q[0].acc_cyc), 64'd2);
                end
                front_seen = 1;
                if (out_ready) begin
                    void'(sb_q.pop_front());
                    front_seen = 0;
                end
            end
        end
        if (in_valid && in_ready) begin
            e.exp = model(stim_q[0]); e.has_gold = stim_q[0].has_gold;
            e.gold = stim_q[0].gold; e.acc_cyc = cyc;
            sb_q.push_back(e);
            void'(stim_q.pop_front());
            n_acc++;
        end
        last_in_ready = in_ready;
        @(posedge clk);
        cyc++;
    endtask

    task automatic drain(input string tag, input int budget, input bit rnd);
        int n = 0;
        while ((stim_q.size() > 0 || sb_q.size() > 0) && n < budget) begin
            step(rnd ? ($urandom_range(0,3) != 0) : 1'b1, rnd);
            n++;
        end
        chk(tag, 64'(stim_q.size() + sb_q.size()), 64'd0);
    endtask

    stim_t g;
    int base;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 0;
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_outputs", 64'(dut_pk()), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);

        // Directed cases with fixed expected results
        g = mk(0, 0, 15, 15, 22'h100000, 11'h400, 0, 4'd1);
        g.has_gold = 1; g.gold = pk(36'h800000, 0, 7'd28, 6'd12, 0, 0, 0, 4'd1);
        stim_q.push_back(g);
        g = mk(0, 1, 15, 15, 22'h100000, 11'h400, 0, 4'd2);
        g.has_gold = 1; g.gold = pk(36'h0, 0, 7'd28, 6'd36, 0, 0, 0, 4'd2);
        stim_q.push_back(g);
        g = mk(0, 1, 15, 15, 22'h100000, 11'h400, 1, 4'd3);
        g.has_gold = 1; g.gold = pk(36'h0, 1, 7'd28, 6'd36, 0, 0, 0, 4'd3);
        stim_q.push_back(g);
        g = mk(0, 1, 15, 16, 22'h100000, 11'h400, 0, 4'd4);
        g.has_gold = 1; g.gold = pk(36'h400000, 1, 7'd28, 6'd13, 0, 0, 0, 4'd4);
        stim_q.push_back(g);
        g = mk(0, 0, 30, 1, 22'h100000, 11'h400, 0, 4'd5);
        g.has_gold = 1; g.gold = pk(36'h400000, 0, 7'd43, 6'd13, 1, 0, 1, 4'd5);
        stim_q.push_back(g);
        g = mk(0, 0, 1, 30, 22'h100000, 11'h400, 0, 4'd6);
        g.has_gold = 1; g.gold = pk(36'h800000000, 0, 7'd30, 6'd0, 1, 1, 0, 4'd6);
        stim_q.push_back(g);
        drain("directed_drain", 50, 0);

        // Backpressure: out_ready low for 3 cycles while 4 ops queue up
        for (int t = 1; t <= 4; t++) begin
            g = rnd_stim(); g.tag = 4'(t); stim_q.push_back(g);
        end
        base = n_acc;
        step(0, 0); step(0, 0); step(0, 0);
        chk("bp_in_ready", 64'(last_in_ready), 64'd0);
        chk("bp_accepted", 64'(n_acc - base), 64'd2);
        drain("bp_drain", 50, 0);
        chk("bp_total", 64'(n_acc - base), 64'd4);

        // Reset with both stages full
        stim_q.push_back(rnd_stim());
        stim_q.push_back(rnd_stim());
        step(0, 0); step(0, 0);
        @(negedge clk);
        reset = 1; in_valid = 0; out_ready = 0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        reset = 0;
        #1;
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        chk("midreset_in_ready", 64'(in_ready), 64'd1);
        sb_q.delete();
        front_seen = 0;
        base = n_outv;
        repeat (10) step(1, 0);
        chk("midreset_stale", 64'(n_outv - base), 64'd0);

        // Randomized traffic with random gaps and backpressure
        for (int i = 0; i < 400; i++) stim_q.push_back(rnd_stim());
        drain("random_drain", 5000, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
